// File: rtl/seg7_bcd_scan_driver.sv
// Binary-to-BCD converter (shift-add-3) feeding a multiplexed
// common-anode 7-segment scanner with leading-zero blanking.
module seg7_bcd_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  BIN,
    output logic [11:0] BCD,
    output logic        BCDVALID,
    output logic [6:0]  SEG7OUT,
    output logic [3:0]  SEG7COM
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    logic [1:0]    state;
    logic [7:0]    sreg;
    logic [11:0]   scratch;
    logic [11:0]   corr;
    logic [2:0]    iter;

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic          gap;

    logic [3:0]    nib;
    logic          blank;
    logic [3:0]    com_sel;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        corr = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            sreg     <= 8'd0;
            scratch  <= 12'd0;
            iter     <= 3'd0;
            BCD      <= 12'h000;
            BCDVALID <= 1'b0;
        end else begin
            BCDVALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sreg    <= BIN;
                    scratch <= 12'd0;
                    iter    <= 3'd0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // hundreds never exceeds 2 for 8-bit input, so corr[11] is always 0
                    scratch <= {corr[10:0], sreg[7]};
                    sreg    <= {sreg[6:0], 1'b0};
                    iter    <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    BCD      <= scratch;
                    BCDVALID <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre <= '0;
            idx <= 2'd0;
            gap <= 1'b0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            gap <= 1'b1;
        end else begin
            pre <= pre + 1'b1;
            gap <= 1'b0;
        end
    end

    always_comb begin
        nib     = BCD[3:0];
        blank   = 1'b0;
        com_sel = 4'b1110;
        case (idx)
            2'd1: begin
                nib     = BCD[7:4];
                blank   = BLANK_LZ && (BCD[11:8] == 4'd0) && (BCD[7:4] == 4'd0);
                com_sel = 4'b1101;
            end
            2'd2: begin
                nib     = BCD[11:8];
                blank   = BLANK_LZ && (BCD[11:8] == 4'd0);
                com_sel = 4'b1011;
            end
            default: begin
                nib     = BCD[3:0];
                blank   = 1'b0;
                com_sel = 4'b1110;
            end
        endcase
    end

    // gap cycle turns all commons off so the old segments never ghost onto the next digit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SEG7COM <= 4'hF;
            SEG7OUT <= 7'h7F;
        end else if (gap) begin
            SEG7COM <= 4'hF;
            SEG7OUT <= 7'h7F;
        end else begin
            SEG7COM <= com_sel;
            SEG7OUT <= blank ? 7'h7F : enc(nib);
        end
    end

endmodule

// File: tb/tb_seg7_bcd_scan_driver.sv
// Directed bench for seg7_bcd_scan_driver: conversion, scan timing,
// blanking with both BLANK_LZ settings, mid-conversion and reset corners.
module tb_seg7_bcd_scan_driver;

    logic        CLK;
    logic        RST;
    logic [7:0]  BIN;
    logic [11:0] bcd_a, bcd_b;
    logic        val_a, val_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  com_a, com_b;

    int total = 0;
    int bad   = 0;

    logic [6:0] cap_a [3];
    logic [6:0] cap_b [3];

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic [6:0]  h1, t1, o1;
        logic [6:0]  h0, t0, o0;
    } vec_t;

    vec_t vecs [7];

    seg7_bcd_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .CLK(CLK), .RST(RST), .BIN(BIN),
        .BCD(bcd_a), .BCDVALID(val_a),
        .SEG7OUT(seg_a), .SEG7COM(com_a)
    );

    seg7_bcd_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .BIN(BIN),
        .BCD(bcd_b), .BCDVALID(val_b),
        .SEG7OUT(seg_b), .SEG7COM(com_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            if (val_a) return;
        end
        total++;
        bad++;
        $display("FAIL wait_valid: got timeout after %0d cycles expected pulse", n);
    endtask

    task automatic capture(input int n);
        for (int d = 0; d < 3; d++) begin
            cap_a[d] = 7'h55;
            cap_b[d] = 7'h55;
        end
        for (int i = 0; i < n; i++) begin
            tick();
            case (com_a)
                4'b1110: cap_a[0] = seg_a;
                4'b1101: cap_a[1] = seg_a;
                4'b1011: cap_a[2] = seg_a;
                default: ;
            endcase
            case (com_b)
                4'b1110: cap_b[0] = seg_b;
                4'b1101: cap_b[1] = seg_b;
                4'b1011: cap_b[2] = seg_b;
                default: ;
            endcase
        end
    endtask

    logic [3:0] exp_com [16];
    logic [6:0] exp_seg;
    int n;
    int early;

    initial begin
        vecs[0] = '{8'd0,   12'h000, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[1] = '{8'd7,   12'h007, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40, 7'h78};
        vecs[2] = '{8'd105, 12'h105, 7'h79, 7'h40, 7'h12, 7'h79, 7'h40, 7'h12};
        vecs[3] = '{8'd255, 12'h255, 7'h24, 7'h12, 7'h12, 7'h24, 7'h12, 7'h12};
        vecs[4] = '{8'd10,  12'h010, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h79, 7'h40};
        vecs[5] = '{8'd99,  12'h099, 7'h7F, 7'h10, 7'h10, 7'h40, 7'h10, 7'h10};
        vecs[6] = '{8'd200, 12'h200, 7'h24, 7'h40, 7'h40, 7'h24, 7'h40, 7'h40};

        exp_com = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                    4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'hE, 4'hE, 4'hE};

        RST = 1'b1;
        BIN = 8'd0;
        repeat (3) tick();
        chk("rst_com", 32'(com_a), 32'hF);
        chk("rst_seg", 32'(seg_a), 32'h7F);
        chk("rst_bcd", 32'(bcd_a), 32'h000);
        chk("rst_valid", 32'(val_a), 32'h0);

        RST = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_seg = (exp_com[i] == 4'hE) ? 7'h40 : 7'h7F;
            chk($sformatf("scan_com[%0d]", i), 32'(com_a), 32'(exp_com[i]));
            chk($sformatf("scan_seg[%0d]", i), 32'(seg_a), 32'(exp_seg));
        end

        for (int v = 0; v < 7; v++) begin
            BIN = vecs[v].bin;
            wait_valid(n);
            wait_valid(n);
            chk($sformatf("bcd[%0d]", vecs[v].bin), 32'(bcd_a), 32'(vecs[v].bcd));
            if (vecs[v].bin == 8'd255) begin
                tick();
                chk("valid_width", 32'(val_a), 32'h0);
                wait_valid(n);
                chk("valid_period", 32'(n + 1), 32'd10);
            end
            capture(16);
            chk($sformatf("lz1_h[%0d]", vecs[v].bin), 32'(cap_a[2]), 32'(vecs[v].h1));
            chk($sformatf("lz1_t[%0d]", vecs[v].bin), 32'(cap_a[1]), 32'(vecs[v].t1));
            chk($sformatf("lz1_o[%0d]", vecs[v].bin), 32'(cap_a[0]), 32'(vecs[v].o1));
            chk($sformatf("lz0_h[%0d]", vecs[v].bin), 32'(cap_b[2]), 32'(vecs[v].h0));
            chk($sformatf("lz0_t[%0d]", vecs[v].bin), 32'(cap_b[1]), 32'(vecs[v].t0));
            chk($sformatf("lz0_o[%0d]", vecs[v].bin), 32'(cap_b[0]), 32'(vecs[v].o0));
        end

        wait_valid(n);
        BIN = 8'd50;
        repeat (3) tick();
        BIN = 8'd200;
        wait_valid(n);
        chk("midchg_first", 32'(bcd_a), 32'h050);
        chk("midchg_lat1", 32'(n), 32'd7);
        wait_valid(n);
        chk("midchg_second", 32'(bcd_a), 32'h200);
        chk("midchg_lat2", 32'(n), 32'd10);

        wait_valid(n);
        BIN = 8'd99;
        repeat (4) tick();
        RST = 1'b1;
        #1;
        chk("midrst_bcd", 32'(bcd_a), 32'h000);
        chk("midrst_valid", 32'(val_a), 32'h0);
        chk("midrst_com", 32'(com_a), 32'hF);
        repeat (2) tick();
        RST = 1'b0;
        early = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (val_a) early++;
        end
        chk("midrst_early", 32'(early), 32'd0);
        tick();
        chk("midrst_valid10", 32'(val_a), 32'h1);
        chk("midrst_bcd10", 32'(bcd_a), 32'h099);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
